// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared status codes and supervisor state encoding for the core run supervisor
// Contents: status_t with codes ST_HOLD/ST_RUN/ST_ACK (also decoded by the cores),
//           supervisor state localparams, sup_state_t enum, and status_for() decoder.
package core_pkg;

    typedef logic [1:0] status_t;

    localparam status_t ST_HOLD = 2'b00;
    localparam status_t ST_RUN  = 2'b01;
    localparam status_t ST_ACK  = 2'b10;

    localparam logic [2:0] SUP_IDLE  = 3'd0;
    localparam logic [2:0] SUP_RUN   = 3'd1;
    localparam logic [2:0] SUP_ACK   = 3'd2;
    localparam logic [2:0] SUP_FIN   = 3'd3;
    localparam logic [2:0] SUP_ABORT = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = SUP_IDLE,
        S_RUN   = SUP_RUN,
        S_ACK   = SUP_ACK,
        S_FIN   = SUP_FIN,
        S_ABORT = SUP_ABORT
    } sup_state_t;

    // Broadcast code for a given state; 2'b11 is never produced.
    function automatic status_t status_for(sup_state_t s);
        case (s)
            S_RUN:   return ST_RUN;
            S_ACK:   return ST_ACK;
            default: return ST_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/core_supervisor_if.sv
// rtl/core_supervisor_if.sv - host and core handshake signals of the run supervisor
// Signals: start, core_en[N], end_process[N] (into supervisor);
//          status[2], busy, done, timeout, done_mask[N], run_cycles[16] (out of supervisor).
// Modports: master = supervisor side, slave = host/core side.
interface core_supervisor_if #(
    parameter int N_CORES = 4
);
    import core_pkg::*;

    logic               start;
    logic [N_CORES-1:0] core_en;
    logic [N_CORES-1:0] end_process;
    status_t            status;
    logic               busy;
    logic               done;
    logic               timeout;
    logic [N_CORES-1:0] done_mask;
    logic [15:0]        run_cycles;

    modport master (
        input  start, core_en, end_process,
        output status, busy, done, timeout, done_mask, run_cycles
    );

    modport slave (
        output start, core_en, end_process,
        input  status, busy, done, timeout, done_mask, run_cycles
    );

endinterface

// File: rtl/core_supervisor_sat_counter16.sv
// rtl/core_supervisor_sat_counter16.sv - 16-bit up-counter with synchronous clear, saturating at 16'hFFFF
// Ports: clock, reset (async, active-high), clear, enable, count[16].
module sat_counter16 (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    output logic [15:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= 16'd0;
        end else if (clear) begin
            count <= 16'd0;
        end else if (enable && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/core_supervisor.sv
// rtl/core_supervisor.sv - multi-core run supervisor: broadcasts HOLD/RUN/ACK, collects end_process, reports done/timeout
// Ports: clock, reset (async, active-high), bus (core_supervisor_if.master).
// All outputs are registered; status/busy/done are decoded from the next state so they line up with the state.
module core_supervisor
    import core_pkg::*;
#(
    parameter int N_CORES        = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int ACK_CYCLES     = 4
) (
    input  logic              clock,
    input  logic              reset,
    core_supervisor_if.master bus
);

    localparam logic [15:0] RUN_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  ACK_LAST = 4'(ACK_CYCLES - 1);

    sup_state_t         state;
    sup_state_t         next_state;
    logic [N_CORES-1:0] en_q;
    logic [N_CORES-1:0] done_mask_q;
    logic [3:0]         ack_cnt;
    logic [15:0]        run_cnt;
    logic [N_CORES-1:0] hits;
    logic               accept;
    logic               all_done;
    logic               run_limit;
    logic               ack_release;

    assign accept      = (state == S_IDLE) && bus.start;
    assign hits        = bus.end_process & en_q;
    // Includes this cycle's hits so a core finishing on the check cycle adds no latency.
    assign all_done    = ((done_mask_q | hits) == en_q);
    assign run_limit   = (run_cnt == RUN_LAST);
    assign ack_release = (ack_cnt >= ACK_LAST) && (hits == '0);

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    next_state = (bus.core_en == '0) ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                // Completion takes priority over the cycle limit.
                if (all_done) begin
                    next_state = S_ACK;
                end else if (run_limit) begin
                    next_state = S_ABORT;
                end
            end
            S_ACK: begin
                if (ack_release) begin
                    next_state = S_FIN;
                end
            end
            S_FIN, S_ABORT: next_state = S_IDLE;
            default:        next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            bus.status  <= ST_HOLD;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.timeout <= 1'b0;
            done_mask_q <= '0;
            en_q        <= '0;
            ack_cnt     <= 4'd0;
        end else begin
            state      <= next_state;
            bus.status <= status_for(next_state);
            bus.busy   <= (next_state != S_IDLE);
            bus.done   <= (next_state == S_FIN);

            if (accept) begin
                en_q        <= bus.core_en;
                done_mask_q <= '0;
                bus.timeout <= 1'b0;
            end else if (state == S_RUN) begin
                done_mask_q <= done_mask_q | hits;
            end

            if (next_state == S_ABORT) begin
                bus.timeout <= 1'b1;
            end

            // Held at zero outside ACK, so it always starts from 0 on entry.
            if (state != S_ACK) begin
                ack_cnt <= 4'd0;
            end else if (ack_cnt != 4'hF) begin
                ack_cnt <= ack_cnt + 4'd1;
            end
        end
    end

    sat_counter16 u_run_cycles (
        .clock  (clock),
        .reset  (reset),
        .clear  (accept),
        .enable (state == S_RUN),
        .count  (run_cnt)
    );

    assign bus.done_mask  = done_mask_q;
    assign bus.run_cycles = run_cnt;

endmodule

// File: tb/tb_core_supervisor.sv
// tb/tb_core_supervisor.sv - directed self-checking bench for core_supervisor
module tb_core_supervisor;

    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;

    core_supervisor_if #(.N_CORES(4)) bus_a ();
    core_supervisor_if #(.N_CORES(4)) bus_b ();

    core_supervisor #(.N_CORES(4), .TIMEOUT_CYCLES(65535), .ACK_CYCLES(4)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a.master)
    );

    core_supervisor #(.N_CORES(4), .TIMEOUT_CYCLES(10), .ACK_CYCLES(4)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clean_reset();
        bus_a.start = 1'b0; bus_a.core_en = '0; bus_a.end_process = '0;
        bus_b.start = 1'b0; bus_b.core_en = '0; bus_b.end_process = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        vectors++; if (bus_a.status !== 2'b00) begin $display("FAIL reset_status got %b exp 00", bus_a.status); miscompares++; end
        vectors++; if (bus_a.busy !== 1'b0) begin $display("FAIL reset_busy got %b exp 0", bus_a.busy); miscompares++; end
        vectors++; if (bus_a.done !== 1'b0) begin $display("FAIL reset_done got %b exp 0", bus_a.done); miscompares++; end
        vectors++; if (bus_a.timeout !== 1'b0) begin $display("FAIL reset_timeout got %b exp 0", bus_a.timeout); miscompares++; end
        vectors++; if (bus_a.done_mask !== 4'b0000) begin $display("FAIL reset_done_mask got %b exp 0000", bus_a.done_mask); miscompares++; end
        vectors++; if (bus_a.run_cycles !== 16'd0) begin $display("FAIL reset_run_cycles got %0d exp 0", bus_a.run_cycles); miscompares++; end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [3:0] ep;
        logic [1:0] exp_st;
        bus_a.core_en = 4'b1111; bus_a.end_process = '0; bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        for (int c = 1; c <= 27; c++) begin
            ep = 4'b0000;
            if (c >= 5)  ep[0] = 1'b1;
            if (c >= 9)  ep[1] = 1'b1;
            if (c >= 12) ep[2] = 1'b1;
            if (c >= 20) ep[3] = 1'b1;
            if (c >= 23) ep = 4'b0000;
            bus_a.end_process = ep;
            exp_st = (c <= 20) ? 2'b01 : (c <= 24) ? 2'b10 : 2'b00;
            vectors++; if (bus_a.status !== exp_st) begin $display("FAIL basic_status cycle %0d got %b exp %b", c, bus_a.status, exp_st); miscompares++; end
            vectors++; if (bus_a.done !== (c == 25)) begin $display("FAIL basic_done cycle %0d got %b exp %b", c, bus_a.done, (c == 25)); miscompares++; end
            tick();
        end
        vectors++; if (bus_a.done_mask !== 4'b1111) begin $display("FAIL basic_done_mask got %b exp 1111", bus_a.done_mask); miscompares++; end
        vectors++; if (bus_a.run_cycles !== 16'd20) begin $display("FAIL basic_run_cycles got %0d exp 20", bus_a.run_cycles); miscompares++; end
        vectors++; if (bus_a.busy !== 1'b0) begin $display("FAIL basic_busy_end got %b exp 0", bus_a.busy); miscompares++; end
    endtask

    task automatic test_masked();
        logic [3:0] ep;
        logic [1:0] exp_st;
        bus_a.core_en = 4'b0101; bus_a.end_process = 4'b0010; bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            ep = 4'b0010;
            if (c >= 3 && c <= 6) ep[0] = 1'b1;
            if (c == 6) ep[2] = 1'b1;
            bus_a.end_process = ep;
            exp_st = (c <= 6) ? 2'b01 : (c <= 10) ? 2'b10 : 2'b00;
            vectors++; if (bus_a.status !== exp_st) begin $display("FAIL masked_status cycle %0d got %b exp %b", c, bus_a.status, exp_st); miscompares++; end
            vectors++; if (bus_a.done !== (c == 11)) begin $display("FAIL masked_done cycle %0d got %b exp %b", c, bus_a.done, (c == 11)); miscompares++; end
            if (c == 7) begin
                vectors++; if (bus_a.done_mask !== 4'b0101) begin $display("FAIL masked_done_mask got %b exp 0101", bus_a.done_mask); miscompares++; end
            end
            tick();
        end
        vectors++; if (bus_a.run_cycles !== 16'd6) begin $display("FAIL masked_run_cycles got %0d exp 6", bus_a.run_cycles); miscompares++; end
        bus_a.end_process = '0;
    endtask

    task automatic test_empty_mask();
        bus_a.core_en = 4'b0000; bus_a.end_process = '0; bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        vectors++; if (bus_a.done !== 1'b1) begin $display("FAIL empty_done got %b exp 1", bus_a.done); miscompares++; end
        vectors++; if (bus_a.status !== 2'b00) begin $display("FAIL empty_status got %b exp 00", bus_a.status); miscompares++; end
        vectors++; if (bus_a.busy !== 1'b1) begin $display("FAIL empty_busy_fin got %b exp 1", bus_a.busy); miscompares++; end
        vectors++; if (bus_a.run_cycles !== 16'd0) begin $display("FAIL empty_run_cycles got %0d exp 0", bus_a.run_cycles); miscompares++; end
        tick();
        vectors++; if (bus_a.done !== 1'b0) begin $display("FAIL empty_done_width got %b exp 0", bus_a.done); miscompares++; end
        vectors++; if (bus_a.status !== 2'b00) begin $display("FAIL empty_status_idle got %b exp 00", bus_a.status); miscompares++; end
        vectors++; if (bus_a.busy !== 1'b0) begin $display("FAIL empty_busy_idle got %b exp 0", bus_a.busy); miscompares++; end
    endtask

    task automatic test_timeout();
        logic [1:0] exp_st;
        bus_b.core_en = 4'b0011; bus_b.end_process = '0; bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            bus_b.end_process = (c >= 2) ? 4'b0001 : 4'b0000;
            exp_st = (c <= 10) ? 2'b01 : 2'b00;
            vectors++; if (bus_b.status !== exp_st) begin $display("FAIL timeout_status cycle %0d got %b exp %b", c, bus_b.status, exp_st); miscompares++; end
            vectors++; if (bus_b.timeout !== (c == 11)) begin $display("FAIL timeout_flag cycle %0d got %b exp %b", c, bus_b.timeout, (c == 11)); miscompares++; end
            vectors++; if (bus_b.done !== 1'b0) begin $display("FAIL timeout_no_done cycle %0d got %b exp 0", c, bus_b.done); miscompares++; end
            tick();
        end
        bus_b.end_process = '0;
        vectors++; if (bus_b.timeout !== 1'b1) begin $display("FAIL timeout_sticky got %b exp 1", bus_b.timeout); miscompares++; end
        vectors++; if (bus_b.busy !== 1'b0) begin $display("FAIL timeout_busy_idle got %b exp 0", bus_b.busy); miscompares++; end
        vectors++; if (bus_b.run_cycles !== 16'd10) begin $display("FAIL timeout_run_cycles got %0d exp 10", bus_b.run_cycles); miscompares++; end
        vectors++; if (bus_b.done !== 1'b0) begin $display("FAIL timeout_no_done_idle got %b exp 0", bus_b.done); miscompares++; end
        bus_b.core_en = 4'b0001; bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        vectors++; if (bus_b.timeout !== 1'b0) begin $display("FAIL timeout_clear got %b exp 0", bus_b.timeout); miscompares++; end
        vectors++; if (bus_b.status !== 2'b01) begin $display("FAIL timeout_restart_status got %b exp 01", bus_b.status); miscompares++; end
        clean_reset();
    endtask

    task automatic test_simultaneous();
        bus_b.core_en = 4'b0011; bus_b.end_process = '0; bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            bus_b.end_process = {2'b00, (c >= 10), (c >= 2)};
            vectors++; if (bus_b.status !== 2'b01) begin $display("FAIL simul_status cycle %0d got %b exp 01", c, bus_b.status); miscompares++; end
            tick();
        end
        vectors++; if (bus_b.status !== 2'b10) begin $display("FAIL simul_ack got %b exp 10", bus_b.status); miscompares++; end
        vectors++; if (bus_b.timeout !== 1'b0) begin $display("FAIL simul_timeout got %b exp 0", bus_b.timeout); miscompares++; end
        vectors++; if (bus_b.done_mask !== 4'b0011) begin $display("FAIL simul_done_mask got %b exp 0011", bus_b.done_mask); miscompares++; end
        vectors++; if (bus_b.run_cycles !== 16'd10) begin $display("FAIL simul_run_cycles got %0d exp 10", bus_b.run_cycles); miscompares++; end
        clean_reset();
    endtask

    task automatic test_reset_mid_run();
        int found;
        bus_a.core_en = 4'b1111; bus_a.end_process = '0; bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            bus_a.end_process = (c >= 3) ? 4'b0001 : 4'b0000;
            tick();
        end
        vectors++; if (bus_a.status !== 2'b01) begin $display("FAIL midrst_pre_status got %b exp 01", bus_a.status); miscompares++; end
        vectors++; if (bus_a.done_mask !== 4'b0001) begin $display("FAIL midrst_pre_mask got %b exp 0001", bus_a.done_mask); miscompares++; end
        #2 reset = 1'b1;
        #1;
        vectors++; if (bus_a.status !== 2'b00) begin $display("FAIL midrst_status got %b exp 00", bus_a.status); miscompares++; end
        vectors++; if (bus_a.busy !== 1'b0) begin $display("FAIL midrst_busy got %b exp 0", bus_a.busy); miscompares++; end
        vectors++; if (bus_a.done_mask !== 4'b0000) begin $display("FAIL midrst_mask got %b exp 0000", bus_a.done_mask); miscompares++; end
        vectors++; if (bus_a.run_cycles !== 16'd0) begin $display("FAIL midrst_run_cycles got %0d exp 0", bus_a.run_cycles); miscompares++; end
        bus_a.end_process = '0;
        @(negedge clock);
        reset = 1'b0;
        tick();
        bus_a.core_en = 4'b0001; bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        vectors++; if (bus_a.status !== 2'b01) begin $display("FAIL midrst_run_status got %b exp 01", bus_a.status); miscompares++; end
        tick();
        bus_a.end_process = 4'b0001;
        tick();
        bus_a.end_process = 4'b0000;
        vectors++; if (bus_a.status !== 2'b10) begin $display("FAIL midrst_ack got %b exp 10", bus_a.status); miscompares++; end
        found = -1;
        for (int c = 3; c < 20 && found < 0; c++) begin
            if (bus_a.done === 1'b1) found = c;
            else tick();
        end
        vectors++; if (found != 7) begin $display("FAIL midrst_done_cycle got %0d exp 7", found); miscompares++; end
        vectors++; if (bus_a.done_mask !== 4'b0001) begin $display("FAIL midrst_done_mask got %b exp 0001", bus_a.done_mask); miscompares++; end
        vectors++; if (bus_a.run_cycles !== 16'd2) begin $display("FAIL midrst_run_cycles got %0d exp 2", bus_a.run_cycles); miscompares++; end
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        bus_a.start = 1'b0; bus_a.core_en = '0; bus_a.end_process = '0;
        bus_b.start = 1'b0; bus_b.core_en = '0; bus_b.end_process = '0;
        test_reset();
        test_basic();
        test_masked();
        test_empty_mask();
        test_timeout();
        test_simultaneous();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/core_supervisor.md
Name: core_supervisor

Overview:
- Multi-core run supervisor. It is the controlling end of each core's status[1:0] / end_process handshake.
- Broadcasts a run/hold/acknowledge code to all matrix-multiplication cores and collects each enabled core's end_process.
- Issues a single done pulse, or a timeout, to the host side of the FPGA design.
- Sits at top level, beside the data and instruction memories.

Parameters:
- N_CORES, 4, number of cores supervised (1..8).
- TIMEOUT_CYCLES, 65535, RUN-state cycle limit before abort (must be < 2^16).
- ACK_CYCLES, 4, minimum cycles ACK code is held before checking end_process release (1..15).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  launch request; honoured only in IDLE.
- core_en  in  N_CORES  per-core enable mask; sampled on accepted start.
- end_process  in  N_CORES  per-core completion level, bit i from core i.
- status  out  2  broadcast code to all cores: 00 HOLD, 01 RUN, 10 ACK, 11 never driven.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on successful completion.
- timeout  out  1  sticky abort flag; cleared on next accepted start.
- done_mask  out  N_CORES  latched per-core completion bits.
- run_cycles  out  16  cycles spent in RUN for the last or current run.

Behaviour:
- Reset (async, immediate) values: state=IDLE, status=00, busy=0, done=0, timeout=0, done_mask=0, run_cycles=0, en_q=0, ack counter=0.
- Reset asserted mid-run forces all outputs to reset values at once. Cores see HOLD.
- States: IDLE, RUN, ACK, FIN, ABORT. status is a registered output decoded from next-state.

IDLE:
- status=00.
- start=1 at edge k: en_q<=core_en, done_mask<=0, run_cycles<=0, timeout<=0.
- If core_en==0, go to FIN; otherwise go to RUN. status=01 is visible from cycle k+1.

RUN:
- status=01.
- Each cycle: done_mask <= done_mask | (end_process & en_q). Bits of disabled cores stay 0 and are never required.
- run_cycles increments each RUN cycle and saturates at 16'hFFFF.
- When (done_mask | (end_process & en_q)) == en_q, go to ACK. This includes a core finishing in the same cycle as the last check, so no extra cycle is added.
- Else if run_cycles == TIMEOUT_CYCLES-1, go to ABORT. If completion and timeout occur in the same cycle, completion wins.
- start is ignored.

ACK:
- status=10. The ack counter loads 0 on entry and counts up.
- Leave for FIN when counter >= ACK_CYCLES-1 and (end_process & en_q) == 0.
- There is no timeout in ACK; a core that holds end_process keeps the block in ACK.

FIN:
- One cycle. done=1, status=00. Return to IDLE.
- done_mask and run_cycles hold until the next accepted start.

ABORT:
- One cycle. status=00, timeout<=1. Return to IDLE. done is not pulsed.

Other rules:
- end_process is assumed synchronous to clock; no synchroniser.
- end_process seen in IDLE or ACK is never latched into done_mask.
- busy = (state != IDLE), registered.

Decomposition:
- Shared package core_pkg holds:
  - status codes ST_HOLD=2'b00, ST_RUN=2'b01, ST_ACK=2'b10;
  - the supervisor state encoding as a localparam set.
- core_2 decodes the same status constants from this package.
- One natural sub-module: sat_counter16 (clear, enable, saturating 16-bit up-counter), used for run_cycles.
- The ACK counter stays inline.

Test Plan:
- Basic run: N_CORES=4, core_en=4'b1111, start at cycle 0. Raise end_process bits 0,1,2,3 at cycles 5,9,12,20, each held. Required: status=01 from cycle 1; ACK from cycle 21; done_mask=4'b1111; run_cycles=20.
  - Drop all end_process at cycle 23 → required: ACK held through cycle 24 (ACK_CYCLES=4), FIN at cycle 25, done pulse exactly 1 cycle.
- Masked cores: core_en=4'b0101, only cores 0 and 2 finish → required: ACK entered, done_mask=4'b0101. end_process[1]=1 throughout must be ignored.
- Empty mask: core_en=0, start → required: FIN the next cycle, done=1, status never 01, run_cycles=0.
- Timeout: TIMEOUT_CYCLES=10, one core never finishes → required: ABORT after 10 RUN cycles, timeout=1, status=00, no done pulse.
  - Then start again → required: timeout clears the cycle start is accepted.
- Simultaneous completion and timeout: last end_process rises on the RUN cycle where run_cycles=TIMEOUT_CYCLES-1 → required: ACK entered, timeout stays 0.
- Reset mid-RUN: assert reset asynchronously between clock edges at cycle 7 → required: status=00, busy=0, done_mask=0 immediately, before the next edge. start after reset release → required: normal run.
